// File: rtl/step_sequencer.sv
// Pattern step sequencer feeding the synth voice.
//
// Holds a STEPS-entry pattern RAM (note, on, tie per entry) written through a
// simple write port. While `run` is high the sequencer advances one step every
// max(tempo_count, 2) clocks. For each sounding step it drives `trig` for
// min(gate_count, T-1) clocks, so untied notes always get a retrigger gap.
// A tied next step keeps `trig` high across the boundary (legato).
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   run           1 = play, 0 = stop (restart always begins at step 0)
//   tempo_count   clocks per step (values < 2 behave as 2)
//   gate_count    clocks of trig per sounding step
//   length        active steps 1..STEPS (0 or > STEPS behaves as STEPS)
//   wr_*          pattern RAM write port
//   trig          gate to the synth
//   osc_count     pitch (half-period) to the synth
//   step_idx      current step
//   step_strobe   one-cycle pulse at every step start
module step_sequencer #(
    parameter int unsigned STEPS   = 16,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned TEMPO_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo_count,
    input  logic [TEMPO_W-1:0] gate_count,
    input  logic [STEP_W:0]    length,
    input  logic               wr_en,
    input  logic [STEP_W-1:0]  wr_addr,
    input  logic [15:0]        wr_note,
    input  logic               wr_on,
    input  logic               wr_tie,
    output logic               trig,
    output logic [15:0]        osc_count,
    output logic [STEP_W-1:0]  step_idx,
    output logic               step_strobe
);

    localparam logic [STEP_W:0]    LEN_MAX = (STEP_W+1)'(STEPS);
    localparam logic [TEMPO_W-1:0] T_MIN   = TEMPO_W'(2);
    localparam logic [TEMPO_W-1:0] ONE     = TEMPO_W'(1);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e             state;
    logic [TEMPO_W-1:0] cnt;
    logic               cur_on;

    logic [15:0]        note_mem [STEPS];
    logic [STEPS-1:0]   on_mem;
    logic [STEPS-1:0]   tie_mem;

    logic [TEMPO_W-1:0] t_eff;
    logic [TEMPO_W-1:0] gate_eff;
    logic [TEMPO_W-1:0] cnt_inc;
    logic [STEP_W:0]    len_eff;
    logic               boundary;
    logic [STEP_W-1:0]  start_idx;
    logic [STEP_W-1:0]  start_next;
    logic               start_tie;
    logic               hold_tie;

    // Successor of idx; an index already beyond a shortened length wraps to 0.
    function automatic logic [STEP_W-1:0] next_idx(input logic [STEP_W-1:0] idx,
                                                   input logic [STEP_W:0]   len);
        logic [STEP_W:0] inc;
        inc = {1'b0, idx} + (STEP_W+1)'(1);
        return (inc >= len) ? '0 : inc[STEP_W-1:0];
    endfunction

    always_comb begin
        t_eff      = (tempo_count < T_MIN) ? T_MIN : tempo_count;
        gate_eff   = (gate_count > t_eff - ONE) ? t_eff - ONE : gate_count;
        len_eff    = (length == '0 || length > LEN_MAX) ? LEN_MAX : length;
        boundary   = (cnt >= t_eff - ONE);
        cnt_inc    = cnt + ONE;
        // Step that starts at the next edge (from IDLE this is always step 0).
        start_idx  = (state == StIdle) ? '0 : next_idx(step_idx, len_eff);
        start_next = next_idx(start_idx, len_eff);
        // Tie lookahead for the step about to start, and for the playing step
        // (whose successor is start_idx while in PLAY).
        start_tie  = on_mem[start_idx] & on_mem[start_next] & tie_mem[start_next];
        hold_tie   = cur_on & on_mem[start_idx] & tie_mem[start_idx];
    end

    // Pattern RAM as a register array so it clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                note_mem[i] <= '0;
            end
            on_mem  <= '0;
            tie_mem <= '0;
        end else if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            on_mem[wr_addr]   <= wr_on;
            tie_mem[wr_addr]  <= wr_tie;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            cur_on      <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            trig        <= 1'b0;
            osc_count   <= '0;
        end else begin
            step_strobe <= 1'b0;
            if (!run) begin
                state    <= StIdle;
                cnt      <= '0;
                step_idx <= '0;
                trig     <= 1'b0;
            end else if (state == StIdle || boundary) begin
                // Step start: latch the entry; the counter restarts at 0.
                state       <= StPlay;
                cnt         <= '0;
                step_idx    <= start_idx;
                step_strobe <= 1'b1;
                cur_on      <= on_mem[start_idx];
                trig        <= on_mem[start_idx] & ((gate_eff != '0) | start_tie);
                // Rests keep the previous pitch for the release tail.
                if (on_mem[start_idx]) begin
                    osc_count <= note_mem[start_idx];
                end
            end else begin
                cnt  <= cnt_inc;
                trig <= cur_on & ((cnt_inc < gate_eff) | hold_tie);
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

    localparam int STEPS   = 16;
    localparam int STEP_W  = 4;
    localparam int TEMPO_W = 24;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               run = 1'b0;
    logic [TEMPO_W-1:0] tempo_count = '0;
    logic [TEMPO_W-1:0] gate_count = '0;
    logic [STEP_W:0]    length = '0;
    logic               wr_en = 1'b0;
    logic [STEP_W-1:0]  wr_addr = '0;
    logic [15:0]        wr_note = '0;
    logic               wr_on = 1'b0;
    logic               wr_tie = 1'b0;
    logic               trig;
    logic [15:0]        osc_count;
    logic [STEP_W-1:0]  step_idx;
    logic               step_strobe;

    step_sequencer #(
        .STEPS  (STEPS),
        .STEP_W (STEP_W),
        .TEMPO_W(TEMPO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .tempo_count(tempo_count),
        .gate_count (gate_count),
        .length     (length),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .wr_on      (wr_on),
        .wr_tie     (wr_tie),
        .trig       (trig),
        .osc_count  (osc_count),
        .step_idx   (step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Expected behaviour of one step: index, pitch at its start, length in
    // clocks and the trig level for every clock of the step.
    typedef struct {
        int          idx;
        int          osc;
        int          t;
        logic [31:0] mask;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Reference model state.
    int m_note[STEPS];
    bit m_on[STEPS];
    bit m_tie[STEPS];
    int m_tempo, m_gate, m_len, m_osc, m_cur;

    function automatic int eff_len();
        return (m_len == 0 || m_len > STEPS) ? STEPS : m_len;
    endfunction

    function automatic int after(int s);
        return (s + 1 >= eff_len()) ? 0 : s + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_note[i] = 0;
            m_on[i]   = 1'b0;
            m_tie[i]  = 1'b0;
        end
        m_osc = 0;
        m_cur = -1;
    endfunction

    // Queue the expected outcome of the next n steps.
    function automatic void plan(int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   s, nx, t, g;
            bit   hold;
            s    = (m_cur < 0) ? 0 : after(m_cur);
            nx   = after(s);
            t    = (m_tempo < 2) ? 2 : m_tempo;
            g    = (m_gate < t - 1) ? m_gate : t - 1;
            hold = m_on[s] && m_on[nx] && m_tie[nx];
            if (m_on[s]) m_osc = m_note[s];
            e.idx  = s;
            e.osc  = m_osc;
            e.t    = t;
            e.mask = '0;
            for (int c = 0; c < t; c++) begin
                e.mask[c] = m_on[s] && (c < g || hold);
            end
            exp_q.push_back(e);
            m_cur = s;
        end
    endfunction

    task automatic apply();
        tempo_count = TEMPO_W'(m_tempo);
        gate_count  = TEMPO_W'(m_gate);
        length      = (STEP_W+1)'(m_len);
    endtask

    task automatic wr(int a, int n, bit on, bit tie);
        wr_en   = 1'b1;
        wr_addr = STEP_W'(a);
        wr_note = 16'(n);
        wr_on   = on;
        wr_tie  = tie;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        m_note[a] = n;
        m_on[a]   = on;
        m_tie[a]  = tie;
    endtask

    // Returns 1 ns after the edge that raised step_strobe.
    task automatic wait_strobe();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!step_strobe && n < 200);
        check("strobe_timeout", int'(step_strobe), 1);
    endtask

    task automatic play(int n);
        for (int i = 0; i < n; i++) wait_strobe();
    endtask

    // Called right after a strobe: let the step finish, then stop at its boundary.
    task automatic stop_end();
        int t;
        t = (m_tempo < 2) ? 2 : m_tempo;
        repeat (t - 1) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        run    = 1'b0;
        @(posedge clk);
        #1;
        check("stop_trig", int'(trig), 0);
        check("stop_idx", int'(step_idx), 0);
        check("stop_strobe", int'(step_strobe), 0);
        check("stop_osc", int'(osc_count), m_osc);
        check("queue_drained", exp_q.size(), 0);
        m_cur = -1;
    endtask

    // Monitor: pops one expectation per step_strobe and checks the step.
    exp_t cur;
    int   pos = 0;
    bit   active = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                active = 1'b0;
            end else begin
                if (step_strobe) begin
                    if (active) check("strobe_early", pos, cur.t);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL queue_underflow: strobe at step %0d, none expected",
                                 step_idx);
                        active = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("step_idx", int'(step_idx), cur.idx);
                        check($sformatf("osc s%0d", cur.idx), int'(osc_count), cur.osc);
                        active = 1'b1;
                        pos    = 0;
                    end
                end else if (active && pos >= cur.t) begin
                    check("strobe_period", int'(step_strobe), 1);
                    active = 1'b0;
                end
                if (active && pos < cur.t) begin
                    check($sformatf("trig s%0d c%0d", cur.idx, pos), int'(trig),
                          int'(cur.mask[pos]));
                    pos++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", int'(trig), 0);
        check("rst_osc", int'(osc_count), 0);
        check("rst_idx", int'(step_idx), 0);
        check("rst_strobe", int'(step_strobe), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic playback, then a write to step 0 while it plays.
        m_tempo = 10; m_gate = 4; m_len = 4;
        apply();
        wr(0, 66, 1, 0);
        wr(1, 80, 1, 0);
        wr(2, 1234, 0, 0);
        wr(3, 100, 1, 0);
        plan(5);
        mon_en = 1'b1;
        run    = 1'b1;
        play(5);
        wr(0, 50, 1, 0);
        plan(4);
        play(4);

        // Stop in the middle of the gate.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        run    = 1'b0;
        @(posedge clk);
        #1;
        check("midstop_trig", int'(trig), 0);
        check("midstop_idx", int'(step_idx), 0);
        check("midstop_osc", int'(osc_count), 50);
        m_cur = -1;

        // Gate clamp: every step on, gate longer than the step.
        m_gate = 20;
        apply();
        wr(2, 90, 1, 0);
        plan(5);
        mon_en = 1'b1;
        run    = 1'b1;
        play(5);
        stop_end();

        // Tie from step 0 into step 1.
        m_gate = 4;
        apply();
        wr(0, 66, 1, 0);
        wr(1, 80, 1, 1);
        plan(4);
        mon_en = 1'b1;
        run    = 1'b1;
        play(4);
        stop_end();
        wr(1, 80, 1, 0);

        // Length wrap, shortening below the playing step, then length 0.
        m_tempo = 6; m_gate = 3; m_len = 3;
        apply();
        plan(4);
        mon_en = 1'b1;
        run    = 1'b1;
        play(4);
        plan(2);
        play(2);
        m_len = 2;
        apply();
        plan(2);
        play(2);
        m_len = 0;
        apply();
        plan(17);
        play(17);
        stop_end();

        // Randomized patterns and timing.
        for (int r = 0; r < 3; r++) begin
            m_tempo = int'($urandom_range(0, 12));
            m_gate  = int'($urandom_range(0, 14));
            m_len   = int'($urandom_range(0, 18));
            apply();
            for (int i = 0; i < STEPS; i++) begin
                wr(i, int'($urandom_range(1, 65535)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            end
            plan(20);
            mon_en = 1'b1;
            run    = 1'b1;
            play(20);
            stop_end();
        end

        // Asynchronous reset in the middle of playback.
        m_tempo = 5; m_gate = 2; m_len = 0;
        apply();
        wr(0, 66, 1, 0);
        plan(3);
        mon_en = 1'b1;
        run    = 1'b1;
        play(3);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_trig", int'(trig), 0);
        check("arst_osc", int'(osc_count), 0);
        check("arst_idx", int'(step_idx), 0);
        check("arst_strobe", int'(step_strobe), 0);
        check("arst_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        model_reset();
        plan(4);
        mon_en = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        play(4);
        stop_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
